// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the shared memory.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ack;

  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_ack;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  gnt_id;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    output busy, gnt_id
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    input  busy, gnt_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter for the shared 32x8 memory: IDLE -> ACCESS -> RESP, one-cycle ack.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;

  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  gnt_q;
  logic                  cpu_ack_q;
  logic                  dma_ack_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;

  logic                  any_req;
  logic                  pick_dma;
  logic                  mem_rd_c;
  logic                  mem_wr_c;

  assign any_req = bus.cpu_req | bus.dma_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that was not granted last wins; reset value 1 hands the first tie to the CPU.
  logic last_gnt;
  assign pick_dma = bus.dma_req & (~bus.cpu_req | ~last_gnt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_gnt <= pick_dma;
    end
  end
`else
  assign pick_dma = bus.dma_req & ~bus.cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are decoded from state alone so each lasts exactly the one ACCESS cycle.
  always_comb begin
    state_next = state;
    mem_rd_c   = 1'b0;
    mem_wr_c   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_rd_c   = ~lat_we;
        mem_wr_c   = lat_we;
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      gnt_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_we    <= pick_dma ? bus.dma_we    : bus.cpu_we;
            lat_addr  <= pick_dma ? bus.dma_addr  : bus.cpu_addr;
            lat_wdata <= pick_dma ? bus.dma_wdata : bus.cpu_wdata;
            gnt_q     <= pick_dma;
          end
        end
        // mem_rdata is only meaningful here, one cycle after the read strobe.
        RESP: begin
          if (gnt_q) begin
            dma_ack_q <= 1'b1;
            if (!lat_we) begin
              dma_rdata_q <= bus.mem_rdata;
            end
          end else begin
            cpu_ack_q <= 1'b1;
            if (!lat_we) begin
              cpu_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.mem_rd    = mem_rd_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.busy      = (state != IDLE);
  assign bus.gnt_id    = gnt_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      5:       return 8'h11;
      6:       return 8'h22;
      10:      return 8'h3C;
      default: return 8'(i * 13 + 1);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit is_cpu, input bit req, input bit we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (is_cpu) begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end else begin
      bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: writes commit on the strobe edge; read data appears the cycle after mem_rd,
  // and garbage is driven otherwise so stray sampling of mem_rdata is visible.
  logic [7:0] mem_arr [32];
  initial begin
    for (int i = 0; i < 32; i++) mem_arr[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus.mem_wr === 1'b1) mem_arr[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata <= (bus.mem_rd === 1'b1) ? mem_arr[bus.mem_addr] : 8'($urandom);
    end
  end

  // Transaction model: a grant in cycle S means strobe in S+1, no strobe in S+2, ack in S+3.
  logic [7:0]    shadow [32];
  int            cyc = 0;
  int            m_start = 0;
  bit            m_active = 1'b0;
  bit            m_ok = 1'b0;
  bit            in_acc;
  bit            in_resp;
  bit            win_dma;
  logic          m_we, m_gnt, m_last, e_cpu_ack, e_dma_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, e_cpu_rdata, e_dma_rdata;

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
    forever begin
      @(negedge clk);
      in_acc  = m_active && (cyc == m_start + 1);
      in_resp = m_active && (cyc == m_start + 2);
      if (m_ok) begin
        checkOutput("cpu_ack",   bus.cpu_ack,   e_cpu_ack);
        checkOutput("dma_ack",   bus.dma_ack,   e_dma_ack);
        checkOutput("cpu_rdata", bus.cpu_rdata, e_cpu_rdata);
        checkOutput("dma_rdata", bus.dma_rdata, e_dma_rdata);
        checkOutput("mem_rd",    bus.mem_rd,    in_acc && !m_we);
        checkOutput("mem_wr",    bus.mem_wr,    in_acc && m_we);
        checkOutput("busy",      bus.busy,      in_acc || in_resp);
        checkOutput("gnt_id",    bus.gnt_id,    m_gnt);
        checkOutput("mem_addr",  bus.mem_addr,  m_addr);
        checkOutput("mem_wdata", bus.mem_wdata, m_wdata);
      end
      if (in_acc && m_we) shadow[m_addr] = m_wdata;
      if (!rst) begin
        m_ok = 1'b1; m_active = 1'b0; m_gnt = 1'b0; m_last = 1'b1;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        e_cpu_ack = 1'b0; e_dma_ack = 1'b0; e_cpu_rdata = '0; e_dma_rdata = '0;
      end else begin
        e_cpu_ack = 1'b0;
        e_dma_ack = 1'b0;
        if (in_resp) begin
          m_active = 1'b0;
          if (m_gnt) begin
            e_dma_ack = 1'b1;
            if (!m_we) e_dma_rdata = shadow[m_addr];
          end else begin
            e_cpu_ack = 1'b1;
            if (!m_we) e_cpu_rdata = shadow[m_addr];
          end
        end else if (!in_acc && (bus.cpu_req || bus.dma_req)) begin
          if (bus.cpu_req && bus.dma_req) begin
`ifdef MEM_ARB_RR_EN
            win_dma = (m_last == 1'b0);
`else
            win_dma = 1'b0;
`endif
          end else begin
            win_dma = bus.dma_req;
          end
          m_active = 1'b1;
          m_start  = cyc;
          m_gnt    = win_dma;
          m_last   = win_dma;
          m_we     = win_dma ? bus.dma_we    : bus.cpu_we;
          m_addr   = win_dma ? bus.dma_addr  : bus.cpu_addr;
          m_wdata  = win_dma ? bus.dma_wdata : bus.cpu_wdata;
        end
      end
      cyc++;
    end
  end

  int ackq [$];
  int exp_order [4];
  int got;
  bit cpu_pend = 1'b0;
  bit dma_pend = 1'b0;

  initial begin
    rst = 1'b0;
    applyStimulus(1, 1, 0, 5'h0A, 8'h00);
    applyStimulus(0, 1, 0, 5'h03, 8'h00);
    repeat (2) begin
      step();
      checkOutput("reset_cpu_ack", bus.cpu_ack, 0);
      checkOutput("reset_dma_ack", bus.dma_ack, 0);
      checkOutput("reset_mem_rd",  bus.mem_rd,  0);
      checkOutput("reset_mem_wr",  bus.mem_wr,  0);
      checkOutput("reset_busy",    bus.busy,    0);
      checkOutput("reset_gnt_id",  bus.gnt_id,  0);
    end

    // First idle edge after release: CPU wins the tie and reads 0x0A.
    rst = 1'b1;
    step();
    applyStimulus(0, 0, 0, 5'h03, 8'h00);
    checkOutput("first_gnt_cpu",   bus.gnt_id,   0);
    checkOutput("read_mem_rd",     bus.mem_rd,   1);
    checkOutput("read_mem_addr",   bus.mem_addr, 5'h0A);
    step();
    checkOutput("read_resp_rd",    bus.mem_rd,   0);
    step();
    checkOutput("read_ack",        bus.cpu_ack,   1);
    checkOutput("read_rdata",      bus.cpu_rdata, 8'h3C);
    applyStimulus(1, 0, 0, 5'h0A, 8'h00);
    step();
    checkOutput("read_ack_clear",  bus.cpu_ack,   0);

    // DMA write 0xA5 to 0x1F, then CPU reads it back.
    applyStimulus(0, 1, 1, 5'h1F, 8'hA5);
    step();
    checkOutput("dwr_mem_wr",      bus.mem_wr,    1);
    checkOutput("dwr_mem_addr",    bus.mem_addr,  5'h1F);
    checkOutput("dwr_mem_wdata",   bus.mem_wdata, 8'hA5);
    step();
    checkOutput("dwr_mem_wr_once", bus.mem_wr,    0);
    step();
    checkOutput("dwr_ack",         bus.dma_ack,   1);
    checkOutput("dwr_gnt_id",      bus.gnt_id,    1);
    applyStimulus(0, 0, 0, 5'h00, 8'h00);
    applyStimulus(1, 1, 0, 5'h1F, 8'h00);
    repeat (3) step();
    checkOutput("rdback_ack",      bus.cpu_ack,   1);
    checkOutput("rdback_rdata",    bus.cpu_rdata, 8'hA5);
    applyStimulus(1, 0, 0, 5'h00, 8'h00);
    step();

    // Contention: fresh reset so the first tie is the CPU's, then both held for 12 cycles.
    rst = 1'b0;
    step();
    rst = 1'b1;
    applyStimulus(1, 1, 0, 5'h02, 8'h00);
    applyStimulus(0, 1, 0, 5'h04, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      step();
      if (bus.cpu_ack) ackq.push_back(0);
      if (bus.dma_ack) ackq.push_back(1);
      if (i == 12) begin
        applyStimulus(1, 0, 0, 5'h02, 8'h00);
        applyStimulus(0, 0, 0, 5'h04, 8'h00);
      end
    end
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    checkOutput("contend_count", ackq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got = (i < ackq.size()) ? ackq[i] : 9;
      checkOutput($sformatf("contend_order%0d", i), got, exp_order[i]);
    end

    // Reset during ACCESS of a CPU read, then the held request completes 3 cycles later.
    applyStimulus(1, 1, 0, 5'h05, 8'h00);
    step();
    checkOutput("rmid_mem_rd", bus.mem_rd, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    checkOutput("rmid_busy",  bus.busy,    0);
    checkOutput("rmid_noack", bus.cpu_ack, 0);
    step();
    checkOutput("rmid_noack1", bus.cpu_ack, 0);
    step();
    checkOutput("rmid_noack2", bus.cpu_ack, 0);
    step();
    checkOutput("rmid_ack",   bus.cpu_ack,   1);
    checkOutput("rmid_rdata", bus.cpu_rdata, 8'h11);

    // Back-to-back: request stays high through the ack with a new address.
    applyStimulus(1, 1, 0, 5'h06, 8'h00);
    step();
    checkOutput("b2b_mem_rd",   bus.mem_rd,   1);
    checkOutput("b2b_mem_addr", bus.mem_addr, 5'h06);
    checkOutput("b2b_ack_low",  bus.cpu_ack,  0);
    step();
    step();
    checkOutput("b2b_ack",   bus.cpu_ack,   1);
    checkOutput("b2b_rdata", bus.cpu_rdata, 8'h22);
    applyStimulus(1, 0, 0, 5'h06, 8'h00);
    step();

    // Random traffic from two requesters that hold their request until acknowledged.
    repeat (3000) begin
      step();
      rst = ($urandom_range(0, 79) != 0);
      if (bus.cpu_ack) cpu_pend = 1'b0;
      if (bus.dma_ack) dma_pend = 1'b0;
      if (!cpu_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_pend = 1'b1;
          applyStimulus(1, 1, 1'($urandom), 5'($urandom), 8'($urandom));
        end else begin
          bus.cpu_req = 1'b0;
        end
      end
      if (!dma_pend) begin
        if ($urandom_range(0, 2) == 0) begin
          dma_pend = 1'b1;
          applyStimulus(0, 1, 1'($urandom), 5'($urandom), 8'($urandom));
        end else begin
          bus.dma_req = 1'b0;
        end
      end
    end
    rst = 1'b1;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
